// File: rtl/period_meter.sv
// Measures clk cycles between successive rising edges of an asynchronous event line.
// Each completed interval is reported as a one-cycle valid with a saturating period.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   IDLE       | disabled, counter cleared, nothing reported
//   WAIT_FIRST | armed, waiting for the reference rising edge
//   MEASURE    | counting; each edge closes one interval and opens the next
module period_meter #(
   parameter int BITS = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            enable,
   input  logic            event_in,
   output logic [BITS-1:0] period,
   output logic            valid,
   output logic            overflow,
   output logic            busy
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_FIRST = 2'd1,
      MEASURE    = 2'd2
   } state_t;

   localparam logic [BITS-1:0] MAX = '1;

   state_t          state;
   logic            s1;
   logic            s2;
   logic            s3;
   logic            edge_det;
   logic [BITS-1:0] cnt;

   // Synchronizer and edge history keep running while disabled so that
   // re-arming never sees a stale level as a fresh edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= event_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign edge_det = s2 & ~s3;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         period   <= '0;
         valid    <= 1'b0;
         overflow <= 1'b0;
         busy     <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (!enable) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  cnt   <= '0;
                  state <= WAIT_FIRST;
                  busy  <= 1'b0;
               end
               WAIT_FIRST: begin
                  if (edge_det) begin
                     cnt   <= '0;
                     state <= MEASURE;
                     busy  <= 1'b1;
                  end
               end
               MEASURE: begin
                  busy <= 1'b1;
                  if (edge_det) begin
                     // cnt holds N-1 here; MAX in cnt means N went past MAX
                     period   <= (cnt == MAX) ? MAX : cnt + 1'b1;
                     overflow <= (cnt == MAX);
                     valid    <= 1'b1;
                     cnt      <= '0;
                  end else if (cnt != MAX) begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: a 16-bit instance for timing/enable/reset
// behaviour and an 8-bit instance for saturation and overflow.
module tb_period_meter;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable16;
   logic        enable8;
   logic        ev;
   logic [15:0] period16;
   logic        valid16;
   logic        overflow16;
   logic        busy16;
   logic [7:0]  period8;
   logic        valid8;
   logic        overflow8;
   logic        busy8;

   logic        sel8;
   logic [15:0] obs_period;
   logic        obs_valid;
   logic        obs_ovf;
   logic        obs_busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   period_meter #(.BITS(16)) dut16 (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable16),
      .event_in (ev),
      .period   (period16),
      .valid    (valid16),
      .overflow (overflow16),
      .busy     (busy16)
   );

   period_meter #(.BITS(8)) dut8 (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable8),
      .event_in (ev),
      .period   (period8),
      .valid    (valid8),
      .overflow (overflow8),
      .busy     (busy8)
   );

   assign obs_period = sel8 ? {8'h00, period8} : period16;
   assign obs_valid  = sel8 ? valid8 : valid16;
   assign obs_ovf    = sel8 ? overflow8 : overflow16;
   assign obs_busy   = sel8 ? busy8 : busy16;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One-cycle pulse occupying 'spacing' cycles in total. The interval it closes
   // (if any) is reported on the third sampling edge after the pulse.
   task automatic pulse(input string tag, input int spacing, input logic exp_valid,
                        input logic [15:0] exp_period, input logic exp_ovf);
      ev = 1'b1;
      tick();
      ev = 1'b0;
      tick();
      chk({tag, "_early_valid"}, 32'(obs_valid), 32'd0);
      tick();
      chk({tag, "_valid"}, 32'(obs_valid), 32'(exp_valid));
      chk({tag, "_period"}, 32'(obs_period), 32'(exp_period));
      chk({tag, "_ovf"}, 32'(obs_ovf), 32'(exp_ovf));
      chk({tag, "_busy"}, 32'(obs_busy), 32'd1);
      tick();
      chk({tag, "_valid_one_cycle"}, 32'(obs_valid), 32'd0);
      for (int i = 4; i < spacing; i++) tick();
   endtask

   initial begin
      int nvalid;
      int bad_period;

      sel8     = 1'b0;
      reset    = 1'b1;
      enable16 = 1'b0;
      enable8  = 1'b0;
      ev       = 1'b0;
      tick();
      tick();
      chk("rst_period", 32'(period16), 32'd0);
      chk("rst_valid", 32'(valid16), 32'd0);
      chk("rst_ovf", 32'(overflow16), 32'd0);
      chk("rst_busy", 32'(busy16), 32'd0);

      // Pulses every 10 cycles
      reset    = 1'b0;
      enable16 = 1'b1;
      tick();
      tick();
      chk("wait_busy", 32'(busy16), 32'd0);
      pulse("p10_ref", 10, 1'b0, 16'd0, 1'b0);
      for (int i = 0; i < 4; i++) pulse("p10", 10, 1'b1, 16'd10, 1'b0);

      // Square wave: rising edge every 2 cycles
      for (int i = 0; i < 6; i++) begin
         ev = ~ev;
         tick();
      end
      nvalid     = 0;
      bad_period = 0;
      for (int i = 0; i < 20; i++) begin
         ev = ~ev;
         tick();
         if (valid16) begin
            nvalid++;
            if (period16 != 16'd2) bad_period++;
         end
      end
      chk("sq_valid_count", 32'(nvalid), 32'd10);
      chk("sq_bad_periods", 32'(bad_period), 32'd0);
      chk("sq_period", 32'(period16), 32'd2);
      ev = 1'b0;

      // Re-arm, establish period 15, then break an interval with enable low
      enable16 = 1'b0;
      tick();
      tick();
      chk("dis_busy", 32'(busy16), 32'd0);
      enable16 = 1'b1;
      tick();
      pulse("p15_ref", 15, 1'b0, 16'd2, 1'b0);
      pulse("p15", 15, 1'b1, 16'd15, 1'b0);
      ev = 1'b1;
      tick();
      ev = 1'b0;
      tick();
      tick();
      chk("brk_close_valid", 32'(valid16), 32'd1);
      chk("brk_close_period", 32'(period16), 32'd15);
      tick();
      tick();
      enable16 = 1'b0;
      tick();
      tick();
      tick();
      chk("brk_idle_busy", 32'(busy16), 32'd0);
      chk("brk_hold_period", 32'(period16), 32'd15);
      enable16 = 1'b1;
      for (int i = 8; i < 20; i++) begin
         tick();
         chk("brk_no_valid", 32'(valid16), 32'd0);
      end
      pulse("p20_ref", 20, 1'b0, 16'd15, 1'b0);
      pulse("p20", 20, 1'b1, 16'd20, 1'b0);

      // Reset mid-interval, pulse spacing 12
      pulse("p12_a", 12, 1'b1, 16'd20, 1'b0);
      ev = 1'b1;
      tick();
      ev = 1'b0;
      tick();
      tick();
      chk("p12_b_period", 32'(period16), 32'd12);
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_period", 32'(period16), 32'd0);
      chk("mid_rst_valid", 32'(valid16), 32'd0);
      chk("mid_rst_ovf", 32'(overflow16), 32'd0);
      chk("mid_rst_busy", 32'(busy16), 32'd0);
      for (int i = 6; i < 12; i++) begin
         tick();
         chk("mid_rst_no_valid", 32'(valid16), 32'd0);
      end
      pulse("p12_ref", 12, 1'b0, 16'd0, 1'b0);
      pulse("p12", 12, 1'b1, 16'd12, 1'b0);

      // Edge coinciding with enable falling
      ev = 1'b1;
      tick();
      ev = 1'b0;
      tick();
      enable16 = 1'b0;
      tick();
      chk("coinc_valid", 32'(valid16), 32'd0);
      chk("coinc_busy", 32'(busy16), 32'd0);
      chk("coinc_period", 32'(period16), 32'd12);
      tick();
      chk("coinc_valid_late", 32'(valid16), 32'd0);

      // 8-bit instance: saturation at MAX=255
      sel8    = 1'b1;
      enable8 = 1'b1;
      tick();
      tick();
      pulse("b8_ref", 255, 1'b0, 16'd0, 1'b0);
      pulse("b8_255", 256, 1'b1, 16'd255, 1'b0);
      pulse("b8_256", 300, 1'b1, 16'd255, 1'b1);
      pulse("b8_300", 10, 1'b1, 16'd255, 1'b1);
      pulse("b8_10", 10, 1'b1, 16'd10, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
